// File: rtl/adc_pattern_gen_if.sv
// adc_pattern_gen_if
//
// Bundles the configuration, control and sample signals of adc_pattern_gen.
// The generator connects through the slave modport. The driver side (a bench,
// an ADC model or a self-test controller) connects through the master modport.
//
// Parameters: NUM_CH channels, DW bits per sample, PER_W trigger-period bits.
//
// Signals (direction seen from the generator):
//   en_i       in   advance enable
//   load_i     in   load init_i into every channel
//   mode_i     in   0 sawtooth, 1 triangle, 2 constant, 3 LFSR
//   lo_i/hi_i  in   signed limits
//   step_i     in   unsigned increment
//   init_i     in   per-channel start value / LFSR seed, channel 0 in the LSBs
//   trig_per_i in   trigger period minus one, 0 disables the trigger
//   dat_o      out  registered channel samples, channel 0 in the LSBs
//   vld_o      out  sample-update strobe
//   trig_o     out  one-cycle periodic trigger
interface adc_pattern_gen_if #(
  parameter int NUM_CH = 4,
  parameter int DW     = 14,
  parameter int PER_W  = 16
);
  logic                   en_i;
  logic                   load_i;
  logic [1:0]             mode_i;
  logic [DW-1:0]          lo_i;
  logic [DW-1:0]          hi_i;
  logic [DW-1:0]          step_i;
  logic [NUM_CH*DW-1:0]   init_i;
  logic [PER_W-1:0]       trig_per_i;
  logic [NUM_CH*DW-1:0]   dat_o;
  logic                   vld_o;
  logic                   trig_o;

  modport master (
    output en_i, load_i, mode_i, lo_i, hi_i, step_i, init_i, trig_per_i,
    input  dat_o, vld_o, trig_o
  );

  modport slave (
    input  en_i, load_i, mode_i, lo_i, hi_i, step_i, init_i, trig_per_i,
    output dat_o, vld_o, trig_o
  );
endinterface

// File: rtl/adc_pattern_gen.sv
// adc_pattern_gen
//
// Multichannel ADC test-pattern and trigger generator. Every channel produces
// a sawtooth, triangle, constant or 16-bit LFSR sequence between the signed
// limits lo/hi. A programmable counter produces a periodic one-cycle trigger.
//
// Ports:
//   adc_clk_i  generator clock
//   adc_rst_i  asynchronous active-high reset
//   bus        adc_pattern_gen_if.slave (controls in, dat_o/vld_o/trig_o out)
//
// Build option:
//   PATGEN_TRIG_RELOAD_EN  when defined, every trigger pulse also reloads all
//                          channels from init_i. This phase-locks the patterns
//                          to the trigger.
module adc_pattern_gen #(
  parameter int NUM_CH = 4,
  parameter int DW     = 14,
  parameter int PER_W  = 16
) (
  input  logic              adc_clk_i,
  input  logic              adc_rst_i,
  adc_pattern_gen_if.slave  bus
);

  // Two guard bits let dat+step and dat-step be compared with the limits
  // without wrapping at full scale.
  localparam int EW = DW + 2;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
  typedef enum logic [1:0] {
    MODE_SAW   = 2'd0,
    MODE_TRI   = 2'd1,
    MODE_CONST = 2'd2,
    MODE_LFSR  = 2'd3
  } mode_e;

  typedef struct packed {
    logic [DW-1:0] dat;
    dir_e          dir;
    logic [15:0]   lfsr;
  } chState_t;

  localparam chState_t CH_RESET = '{dat: '0, dir: DIR_UP, lfsr: 16'h0001};

  chState_t             chan_q [NUM_CH];
  chState_t             chan_d [NUM_CH];
  logic [PER_W-1:0]     trigCnt_q, trigCnt_d;
  logic                 trig_q, trig_d;
  logic                 vld_q, vld_d;
  logic                 chLoad;
  logic [NUM_CH*DW-1:0] datFlat;

  // Next state of one channel. Load wins over stepping. Otherwise the mode
  // selects how the channel advances.
  function automatic chState_t nextState(
    input chState_t      cur,
    input logic          doLoad,
    input logic          doStep,
    input logic [1:0]    modeSel,
    input logic [DW-1:0] initV,
    input logic [DW-1:0] lo,
    input logic [DW-1:0] hi,
    input logic [DW-1:0] step
  );
    chState_t             nxt;
    logic signed [EW-1:0] d, l, h, s, sum, diff;
    logic [15:0]          seed, lfsrNext;
    nxt      = cur;
    d        = EW'($signed(cur.dat));
    l        = EW'($signed(lo));
    h        = EW'($signed(hi));
    s        = EW'(step);
    sum      = d + s;
    diff     = d - s;
    seed     = 16'(initV);
    // Fibonacci taps 16,14,13,11 (1-based) feed back into bit 0.
    lfsrNext = {cur.lfsr[14:0],
                cur.lfsr[15] ^ cur.lfsr[13] ^ cur.lfsr[12] ^ cur.lfsr[10]};
    if (doLoad) begin
      nxt.dat  = initV;
      nxt.dir  = DIR_UP;
      // An all-zero LFSR would lock up, so a zero seed becomes 1.
      nxt.lfsr = (seed == 16'h0000) ? 16'h0001 : seed;
    end else if (doStep) begin
      case (mode_e'(modeSel))
        MODE_SAW, MODE_TRI: begin
          if (l > h) begin
            nxt.dat = lo;
            nxt.dir = DIR_UP;
          end else if (d < l || d > h) begin
            // The value can be left outside the window after a limit or mode
            // change. Restart the pattern from the bottom.
            nxt.dat = lo;
            nxt.dir = DIR_UP;
          end else if (s == '0) begin
            nxt.dat = cur.dat;
          end else if (mode_e'(modeSel) == MODE_SAW) begin
            if (d >= h)        nxt.dat = lo;
            else if (sum > h)  nxt.dat = hi;
            else               nxt.dat = DW'(sum);
          end else if (cur.dir == DIR_UP) begin
            if (sum >= h) begin
              nxt.dat = hi;
              nxt.dir = DIR_DOWN;
            end else begin
              nxt.dat = DW'(sum);
            end
          end else begin
            if (diff <= l) begin
              nxt.dat = lo;
              nxt.dir = DIR_UP;
            end else begin
              nxt.dat = DW'(diff);
            end
          end
        end
        MODE_LFSR: begin
          nxt.lfsr = lfsrNext;
          // The casting sign-extends bit 15 when DW is wider than 16.
          nxt.dat  = DW'($signed(lfsrNext));
        end
        default: nxt.dat = cur.dat;
      endcase
    end
    return nxt;
  endfunction

  // Trigger counter: load clears it. It advances only while enabled with a
  // non-zero period. A period lowered below the count restarts it silently.
  always_comb begin
    trigCnt_d = trigCnt_q;
    trig_d    = 1'b0;
    if (bus.load_i) begin
      trigCnt_d = '0;
    end else if (bus.en_i && bus.trig_per_i != '0) begin
      if (trigCnt_q == bus.trig_per_i) begin
        trigCnt_d = '0;
        trig_d    = 1'b1;
      end else if (trigCnt_q > bus.trig_per_i) begin
        trigCnt_d = '0;
      end else begin
        trigCnt_d = trigCnt_q + 1'b1;
      end
    end
  end

`ifdef PATGEN_TRIG_RELOAD_EN
  assign chLoad = bus.load_i | trig_d;
`else
  assign chLoad = bus.load_i;
`endif

  assign vld_d = bus.en_i | bus.load_i;

  // Channel next-state for every channel.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      chan_d[i] = nextState(chan_q[i], chLoad, bus.en_i, bus.mode_i,
                            bus.init_i[i*DW +: DW], bus.lo_i, bus.hi_i,
                            bus.step_i);
    end
  end

  // State registers.
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      for (int i = 0; i < NUM_CH; i++) chan_q[i] <= CH_RESET;
      trigCnt_q <= '0;
      trig_q    <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) chan_q[i] <= chan_d[i];
      trigCnt_q <= trigCnt_d;
      trig_q    <= trig_d;
      vld_q     <= vld_d;
    end
  end

  // Pack the channel samples, with channel 0 in the LSBs.
  always_comb begin
    datFlat = '0;
    for (int i = 0; i < NUM_CH; i++) datFlat[i*DW +: DW] = chan_q[i].dat;
  end

  assign bus.dat_o  = datFlat;
  assign bus.vld_o  = vld_q;
  assign bus.trig_o = trig_q;

endmodule
